// File: rtl/pipe_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_pkg
//   Shared types for the 5-stage core hazard sequencer.
//
//   hz_state_t  : sequencer state (normal flow, waiting on the MDU,
//                 waiting for an in-flight fetch before loading a redirect PC)
//   pipe_ctl_t  : one bundle of per-boundary enables and bubble-loads so the
//                 reg_* pipeline register modules each consume a single field
//
//   The CTL_* constants are the output patterns the sequencer selects from.
//   Bit order (MSB first): pc_en fd_en de_en em_en fd_bub de_bub em_bub mw_bub
// ---------------------------------------------------------------------------
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        HZ_RUN        = 2'd0,
        HZ_MDU_WAIT   = 2'd1,
        HZ_REDIR_WAIT = 2'd2
    } hz_state_t;

    typedef struct packed {
        logic pc_en;
        logic fd_en;
        logic de_en;
        logic em_en;
        logic fd_bub;
        logic de_bub;
        logic em_bub;
        logic mw_bub;
    } pipe_ctl_t;

    // Free-flowing pipeline: everything advances, nothing is squashed.
    localparam pipe_ctl_t CTL_RUN       = 8'b1111_0000;
    // Reset: registers load bubbles so the pipe comes up empty.
    localparam pipe_ctl_t CTL_RESET     = 8'b1111_1111;
    // Data memory wait: freeze F..M, send a bubble into W.
    localparam pipe_ctl_t CTL_MEM_STALL = 8'b0000_0001;
    // MDU busy: freeze F..E, the E/M register takes a bubble while M/W drain.
    localparam pipe_ctl_t CTL_MDU_STALL = 8'b0001_0010;
    // Load-use: freeze PC and F/D, inject a bubble into D/E.
    localparam pipe_ctl_t CTL_LOAD_USE  = 8'b0011_0100;
    // Fetch outstanding: hold PC, F/D takes a bubble (no valid instruction yet).
    localparam pipe_ctl_t CTL_IFETCH    = 8'b0111_1000;

endpackage : pipe_hazard_ctrl_pkg

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_sat_counter
//   Saturating up-counter used for the stall-cycle performance counter.
//   Sticks at all-ones instead of wrapping so a long run never reports a
//   misleadingly small number.
//
//   Ports:
//     clk    in  1  clock
//     clear  in  1  synchronous clear (takes priority over inc)
//     inc    in  1  add one this cycle (ignored once saturated)
//     count  out W  current count
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic atMax;

    assign atMax = &count;

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (inc && !atMax) begin
            count <= count + 1'b1;
        end
    end

endmodule : pipe_hazard_ctrl_sat_counter

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Central stall/flush sequencer for the 5-stage core (F, D, E, M, W).
//   Produces the enable and bubble-load controls for the PC and the F/D, D/E,
//   E/M and M/W pipeline registers from the memory waits, load-use hazard,
//   EX branch redirect and the multi-cycle MDU handshake.
//
//   A redirect that arrives while an instruction fetch is still outstanding
//   is parked in pendPc; the PC is only loaded once the wrong-path fetch has
//   returned (and been squashed into F/D as a bubble).
//
//   Ports:
//     clk, reset          clock, synchronous active-high reset
//     iwait               instruction fetch outstanding
//     dwait               data access outstanding in M
//     load_use            D needs the destination of a load in E
//     redirect_valid/pc   EX mispredict and its target
//     mdu_start/mdu_done  multi-cycle MDU handshake
//     pc_en               PC update enable
//     pc_sel_redirect     PC mux selects pc_target instead of pc+4
//     pc_target           redirect target for the PC mux
//     fd_en, de_en, em_en register enables (0 = hold)
//     fd_bub..mw_bub      load a bubble into that register
//     stall_cnt           cycles with pc_en=0 since reset (saturating)
//     dbgState            current sequencer state, for observation only
//
//   All control outputs are combinational from the registered state and the
//   current inputs.
//
//   Handshakes: there is no valid/ready pair here. mdu_start is a one-cycle
//   marker for the first E cycle of an MDU op; mdu_done is a one-cycle
//   completion pulse that may coincide with mdu_start for single-cycle ops.
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int PC_W  = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             iwait,
    input  logic             dwait,
    input  logic             load_use,
    input  logic             redirect_valid,
    input  logic [PC_W-1:0]  redirect_pc,
    input  logic             mdu_start,
    input  logic             mdu_done,
    output logic             pc_en,
    output logic             pc_sel_redirect,
    output logic [PC_W-1:0]  pc_target,
    output logic             fd_en,
    output logic             de_en,
    output logic             em_en,
    output logic             fd_bub,
    output logic             de_bub,
    output logic             em_bub,
    output logic             mw_bub,
    output logic [CNT_W-1:0] stall_cnt,
    output hz_state_t        dbgState
);

    hz_state_t       state;
    hz_state_t       stateNext;
    logic [PC_W-1:0] pendPc;
    logic            latchPend;
    logic            applyRun;
    pipe_ctl_t       ctl;
    logic            selRedirect;
    logic [PC_W-1:0] target;

    // -----------------------------------------------------------------------
    // Output and next-state decode. Priority, highest first:
    //   data wait > MDU busy > MDU start > redirect > load-use > fetch wait.
    // applyRun marks cycles where the RUN-state rules are evaluated, which
    // includes the cycle an MDU op completes (the pipe resumes immediately).
    // -----------------------------------------------------------------------
    always_comb begin
        ctl         = CTL_RUN;
        selRedirect = 1'b0;
        target      = redirect_pc;
        stateNext   = state;
        latchPend   = 1'b0;
        applyRun    = 1'b0;

        if (reset) begin
            ctl    = CTL_RESET;
            target = '0;
        end else if (dwait) begin
            // Everything freezes, including a pending redirect: the fetch
            // return is not acted on until M is free again.
            ctl = CTL_MEM_STALL;
        end else begin
            case (state)
                HZ_MDU_WAIT: begin
                    if (mdu_done) begin
                        stateNext = HZ_RUN;
                        applyRun  = 1'b1;
                    end else begin
                        ctl = CTL_MDU_STALL;
                    end
                end

                HZ_REDIR_WAIT: begin
                    // D/E and E/M keep draining older work; only F/D is
                    // squashed. Further redirects are ignored because E can
                    // only hold bubbles while we are here.
                    ctl.fd_bub = 1'b1;
                    if (iwait) begin
                        ctl.pc_en = 1'b0;
                    end else begin
                        selRedirect = 1'b1;
                        target      = pendPc;
                        stateNext   = HZ_RUN;
                    end
                end

                default: begin
                    applyRun = 1'b1;
                end
            endcase

            if (applyRun) begin
                if (mdu_start) begin
                    if (mdu_done) begin
                        // Single-cycle completion: nothing to wait for.
                        ctl       = CTL_RUN;
                        stateNext = HZ_RUN;
                    end else begin
                        ctl       = CTL_MDU_STALL;
                        stateNext = HZ_MDU_WAIT;
                    end
                end else if (redirect_valid) begin
                    // Redirect beats load_use: the instruction in D is on
                    // the wrong path, so its hazard is irrelevant.
                    ctl.fd_bub = 1'b1;
                    ctl.de_bub = 1'b1;
                    if (iwait) begin
                        ctl.pc_en = 1'b0;
                        latchPend = 1'b1;
                        stateNext = HZ_REDIR_WAIT;
                    end else begin
                        selRedirect = 1'b1;
                        stateNext   = HZ_RUN;
                    end
                end else if (load_use) begin
                    ctl = CTL_LOAD_USE;
                end else if (iwait) begin
                    ctl = CTL_IFETCH;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // State and pending-target registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= HZ_RUN;
            pendPc <= '0;
        end else begin
            state <= stateNext;
            if (latchPend) begin
                pendPc <= redirect_pc;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stall-cycle performance counter. pc_en is forced high during reset, so
    // reset cycles never count.
    // -----------------------------------------------------------------------
    pipe_hazard_ctrl_sat_counter #(
        .W (CNT_W)
    ) u_stallCnt (
        .clk   (clk),
        .clear (reset),
        .inc   (!ctl.pc_en),
        .count (stall_cnt)
    );

    // -----------------------------------------------------------------------
    // Output mapping
    // -----------------------------------------------------------------------
    assign pc_en           = ctl.pc_en;
    assign fd_en           = ctl.fd_en;
    assign de_en           = ctl.de_en;
    assign em_en           = ctl.em_en;
    assign fd_bub          = ctl.fd_bub;
    assign de_bub          = ctl.de_bub;
    assign em_bub          = ctl.em_bub;
    assign mw_bub          = ctl.mw_bub;
    assign pc_sel_redirect = selRedirect;
    assign pc_target       = target;
    assign dbgState        = state;

endmodule : pipe_hazard_ctrl

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage core (F, D, E, M, W).
- Generates per-boundary enable and bubble controls for the PC, F/D, D/E, E/M and M/W pipeline registers.
- Inputs are the memory wait signals, load-use detection, EX branch redirect and the multi-cycle MDU handshake.
- Holds a pending redirect while an instruction fetch is in flight, so the wrong-path fetch is discarded before the new PC is loaded.

Parameters:
- PC_W, 64, width of PC / redirect target
- CNT_W, 32, width of stall-cycle performance counter

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- iwait  in  1  instruction fetch outstanding / not yet returned
- dwait  in  1  data access outstanding in M
- load_use  in  1  D sources the dst of a load currently in E
- redirect_valid  in  1  EX resolved taken branch/jump mispredict
- redirect_pc  in  PC_W  target of redirect
- mdu_start  in  1  E holds a multi-cycle mul/div op in its first cycle
- mdu_done  in  1  MDU result valid this cycle
- pc_en  out  1  PC register update enable
- pc_sel_redirect  out  1  PC loads pc_target instead of pc+4
- pc_target  out  PC_W  redirect target to PC mux
- fd_en, de_en, em_en  out  1 each  register enables (0 = hold)
- fd_bub, de_bub, em_bub, mw_bub  out  1 each  load bubble (is_bubble=1, ctl=0) into that register
- stall_cnt  out  CNT_W  cycles with pc_en=0 since reset

Behaviour:
- All outputs are combinational from the current state and inputs. State, pending PC and counter are registered.
- FSM states:
  - RUN (reset state).
  - MDU_WAIT.
  - REDIR_WAIT, which latches pend_pc.
- Reset values:
  - State RUN, pend_pc=0, stall_cnt=0.
  - While reset=1: pc_en=fd_en=de_en=em_en=1, fd_bub=de_bub=em_bub=mw_bub=1, pc_sel_redirect=0, pc_target=0.
- Defaults: pc_en=fd_en=de_en=em_en=1, all bub=0, pc_sel_redirect=0, pc_target=redirect_pc.
- Priority each cycle, highest first. All states apply this order.
- 1. dwait=1:
  - pc_en=fd_en=de_en=em_en=0, mw_bub=1.
  - State and pend_pc unchanged.
  - The iwait-drop transition of REDIR_WAIT is suppressed this cycle.
- 2. In MDU_WAIT with mdu_done=0:
  - pc_en=fd_en=de_en=0, em_bub=1.
- 2'. In MDU_WAIT with mdu_done=1:
  - Return to RUN and apply RUN rules 3-6 this cycle.
- 3. In RUN with mdu_start=1:
  - Same outputs as 2.
  - Next state MDU_WAIT, unless mdu_done=1 in the same cycle (single-cycle completion), in which case stay in RUN with default outputs.
- 4. redirect_valid=1 (RUN), or any cycle in REDIR_WAIT:
  - fd_bub=de_bub=1 on a new redirect.
  - In REDIR_WAIT only fd_bub=1; de_en/em_en stay 1 so older instructions drain.
  - If iwait=0: pc_en=1, pc_sel_redirect=1, pc_target = redirect_pc (RUN) or pend_pc (REDIR_WAIT); next state RUN.
  - If iwait=1: pc_en=0; latch pend_pc=redirect_pc on entry; next state REDIR_WAIT.
  - Redirect overrides load_use in the same cycle, because D is wrong path.
- 5. load_use=1: pc_en=fd_en=0, de_bub=1.
- 6. iwait=1: pc_en=0, fd_bub=1.
- A new redirect_valid while in REDIR_WAIT is ignored. This is legal because E holds only bubbles.
- redirect_valid and mdu_start are never both 1. The bench asserts this.
- stall_cnt:
  - +1 in every non-reset cycle with pc_en=0.
  - Saturates at 2^CNT_W-1; no wrap.
- Reset asserted in any state returns to RUN next cycle and discards any pending redirect.

Decomposition:
- Shared package common gains:
  - typedef enum hz_state_t {HZ_RUN, HZ_MDU_WAIT, HZ_REDIR_WAIT}.
  - Packed struct pipe_ctl_t {pc_en, fd_en, de_en, em_en, fd_bub, de_bub, em_bub, mw_bub}, so reg_* modules consume one field each.
- Sub-module sat_counter (parameter W; inc, clear) for stall_cnt.

Test Plan:
- Reset held 2 cycles, then idle inputs -> cycle after release: all en=1, all bub=0, stall_cnt=0, state RUN.
- dwait=1 for 3 cycles with load_use=1 and redirect_valid=1 -> all en=0, mw_bub=1 each cycle, pc_sel_redirect=0, stall_cnt=3. After dwait drops, the redirect is served that cycle.
- mdu_start=1, then mdu_done=1 on the 4th cycle -> pc_en=fd_en=de_en=0 and em_bub=1 for 3 cycles. Cycle 4 has default outputs; state returns to RUN.
- redirect_valid=1, redirect_pc=0x8000_0100, iwait=0 -> same cycle: pc_sel_redirect=1, pc_target=0x8000_0100, fd_bub=de_bub=1.
- redirect_valid=1, redirect_pc=0x8000_0200, iwait=1 for 2 more cycles -> REDIR_WAIT with fd_bub=1 and pc_en=0. When iwait=0: pc_en=1, pc_target=0x8000_0200. A redirect_pc change during the wait is ignored.
- Reset in REDIR_WAIT -> next cycle RUN, pc_sel_redirect=0. With stall_cnt preset near max via long iwait, the count saturates at 0xFFFF_FFFF.
